// File: rtl/rv_defs.sv
// Shared core definitions: architectural widths, reset vector and the
// fetch-queue entry layout.
package rv_defs;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;
  localparam logic [XLEN-1:0] RESET_VECTOR = 32'h8000_0000;

  // One fetched instruction together with the address it came from.
  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } fetch_entry_t;

  localparam int unsigned FETCH_ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/ifetch_buf.sv
// Two-entry synchronous FIFO between imem responses and decode.
// The head is driven from registers only, so decode never sees a
// combinational path from imem_data.
module ifetch_buf #(
  parameter int unsigned W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [1:0]   count,
  output logic [W-1:0] head
);

  logic [1:0][W-1:0] slot;
  logic              rd_ptr;
  logic              wr_ptr;
  logic [1:0]        cnt_q;

  // Storage, pointers and occupancy; flush empties the queue and wins over
  // any push or pop in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot   <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      cnt_q  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      if (push) begin
        slot[wr_ptr] <= din;
        wr_ptr       <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign count = cnt_q;
  assign head  = slot[rd_ptr];

endmodule

// File: rtl/ifetch.sv
// Instruction-fetch stage: issues one word address per cycle to imem,
// tracks the single outstanding registered-address read, queues returned
// words and hands them to decode over valid/ready. A redirect flushes
// everything and restarts fetch at the new target in the same cycle.
module ifetch
  import rv_defs::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_VECTOR
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] imem_addr,
  input  logic [ILEN-1:0] imem_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [ILEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc
);

  localparam logic [XLEN-1:0] WORD_MASK = ~(XLEN'(3));

  logic [XLEN-1:0] pc;
  logic            inflight;
  logic [XLEN-1:0] inflight_pc;
  logic [XLEN-1:0] target;
  logic [1:0]      count;
  logic [2:0]      occ_next;
  logic            pop;
  logic            push;
  logic            issue;
  fetch_entry_t    push_e;
  fetch_entry_t    head_e;

  assign target = redirect_pc & WORD_MASK;
  assign pop    = inst_valid & inst_ready & ~redirect_valid;
  // A response arriving during a redirect belongs to the abandoned path.
  assign push   = inflight & ~redirect_valid;

  // Only issue when the eventual response is guaranteed a queue slot;
  // pop only happens with count >= 1, so this never underflows.
  always_comb begin
    occ_next = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    issue    = redirect_valid | (occ_next <= 3'd1);
  end

  assign imem_addr = redirect_valid ? target : pc;

  // Fetch PC and outstanding-request tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect_valid) begin
      pc          <= target + XLEN'(4);
      inflight    <= 1'b1;
      inflight_pc <= target;
    end else if (issue) begin
      pc          <= pc + XLEN'(4);
      inflight    <= 1'b1;
      inflight_pc <= pc;
    end else begin
      inflight    <= 1'b0;
    end
  end

  assign push_e.pc   = inflight_pc;
  assign push_e.inst = imem_data;

  ifetch_buf #(
    .W (FETCH_ENTRY_W)
  ) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   (push_e),
    .count (count),
    .head  (head_e)
  );

  assign inst_valid = (count != 2'd0);
  assign inst       = head_e.inst;
  assign inst_pc    = head_e.pc;

endmodule

// File: doc/ifetch.md
# ifetch

Instruction-fetch stage of the single-issue core. It is the initiator side of the instruction-memory port. It drives a word address every cycle, tracks the one-cycle registered-address read latency of `imem`, and buffers returned words in a 2-entry queue. Words are presented to decode with a valid/ready handshake, and a redirect path is provided for branches, jumps and traps.

## Interface
Parameters:
- `RESET_PC`, default `32'h8000_0000`: first fetch address after reset.

Ports:
- `clk`  in  1  core clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `imem_addr`  out  32  byte address to `imem`; sampled by `imem` every edge.
- `imem_data`  in  32  word for the address sampled at the previous edge.
- `redirect_valid`  in  1  flush and restart fetch at `redirect_pc`.
- `redirect_pc`  in  32  new fetch address; bits [1:0] are ignored and treated as 0.
- `inst_valid`  out  1  `inst`/`inst_pc` hold a valid entry.
- `inst_ready`  in  1  decode accepts the entry this cycle.
- `inst`  out  32  instruction word.
- `inst_pc`  out  32  address of `inst`.

## Operation
State:
- `pc`: next address to issue.
- `inflight` (1 b) and `inflight_pc`: the request sampled by `imem` last edge.
- 2-entry FIFO of {pc, inst} with `count` 0..2.

Rules, evaluated each cycle:
- `pop = inst_valid & inst_ready & ~redirect_valid`.
- `imem_addr = redirect_valid ? {redirect_pc[31:2],2'b00} : pc` (combinational mux).
- Issue condition without redirect: `count + inflight - pop <= 1`. This guarantees the response always has a FIFO slot.
  - On issue: `pc <= pc + 4` (mod 2^32), `inflight <= 1`, `inflight_pc <= pc`.
  - Otherwise: `pc` holds and `inflight <= 0`.
- Response: if `inflight`, push {`inflight_pc`, `imem_data`} this edge.
  - Push and pop may happen in the same cycle. `count` then stays the same and order is preserved.
- Redirect (priority over everything):
  - FIFO cleared, `count <= 0`.
  - In-flight response discarded and not pushed.
  - Pop suppressed.
  - Always issues: `pc <= redirect_pc_aligned + 4`, `inflight <= 1`, `inflight_pc <= redirect_pc_aligned`.
- `inst_valid = (count != 0)`. `inst`/`inst_pc` come from the FIFO head, which is a registered source with no combinational path from `imem_data`.
- Payload stability: while `inst_valid & ~inst_ready`, `inst`/`inst_pc` stay stable until popped or flushed.
- No error or alignment checks beyond clearing bits [1:0]. Out-of-range addresses are passed through unchanged.

## Timing
Reset values while `rst_n` = 0:
- `pc = RESET_PC`, `inflight = 0`, `count = 0`, `inst_valid = 0`.
- `inst` = 0, `inst_pc` = 0.
- `imem_addr = RESET_PC`, unless `redirect_valid` is high.

Latencies:
- First issue occurs in the first cycle after `rst_n` rises. `inst_valid` goes high 2 cycles after that first issue edge.
- Redirect asserted in cycle N: the target is issued in N, data is pushed at the end of N+1, and `inst_valid` is high in N+2. Redirect-to-valid is 2 cycles.

Throughput:
- 1 instruction/cycle sustained with `inst_ready` held high. Steady state is `count` = 1, `inflight` = 1.
- With `inst_ready` low, fetch stops after the FIFO fills (`count` = 2, `inflight` = 0). At most 2 words are outstanding.

Boundary cases:
- Redirect while `count` = 2 and stalled: all entries are dropped.
- Back-to-back redirects: the last one wins, and each restarts the 2-cycle latency.
- Async reset mid-stream: all state clears immediately, and there is no partial push.

## Structure
- Shared header/package `rv_defs`: `XLEN` = 32, `RESET_VECTOR` = `32'h8000_0000` (default for `RESET_PC`), `ILEN` = 32.
- Sub-module `ifetch_buf`: 2-entry synchronous FIFO of width 64 with push, pop, flush, `count`, and head outputs.
- Top-level `ifetch`: `pc`/`inflight` registers, issue logic, redirect mux.
- Bench pairs `ifetch` with `imem` loaded from `program.hex`.

## Test plan
- Reset release, ready = 1, `program.hex` words 0x00000013, 0x00100093, 0x00200113 → `inst_valid` rises 2 cycles after the first issue edge. Outputs (pc, inst) in order are (0x80000000, 0x00000013), (0x80000004, 0x00100093), (0x80000008, 0x00200113), one per cycle.
- ready held 0 for 10 cycles after valid → `count` = 2, `imem_addr` holds 0x80000008, no new issue, and head stays (0x80000000, 0x00000013). Raising ready then yields 0x80000000, 0x80000004, 0x80000008 with no gap or duplicate.
- Redirect to 0x80000043 while `count` = 2 → queued entries are dropped, `imem_addr` = 0x80000040 in the same cycle, and 2 cycles later `inst_pc` = 0x80000040 with word 16.
- Redirect in two consecutive cycles (0x80000020 then 0x80000080) → the first `inst_pc` after that is 0x80000080, and 0x80000020 never appears.
- Random ready (50%) over 200 cycles → `inst_pc` sequence is strictly +4 and each `inst` equals `mem[(pc-0x80000000)>>2]`.
- Assert `rst_n` low mid-stream with `count` = 2 → `inst_valid` drops immediately. After release, fetch restarts at 0x80000000.
